pu_feeder: RTL and testbench
============================

# pu_feeder

Front-end sequencer for the 4-input processing unit. It buffers incoming 4-element float32 input vectors and holds the 4 weights. It issues one vector per cycle to the PU's x1..x4/w1..w4 inputs and tracks the PU pipeline latency. It then captures the ReLU'd dot-product result into a result FIFO with a valid/ready output. It is the producer/consumer counterpart sitting on the PU's x/w inputs and out port.

## Interface
- DEPTH, 4: entries in the input FIFO and in the result FIFO; power of two, ≥2.
- PU_LAT, 1: cycles from issue (pu_x* driven) to the matching pu_out being valid.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- w_load  in  1  weight load request.
- w_in  in  128  weights; [31:0]=w1 … [127:96]=w4.
- w_ready  out  1  weight load accepted when w_load && w_ready.
- in_valid  in  1  input vector valid.
- in_data  in  128  vector; [31:0]=x1 … [127:96]=x4.
- in_ready  out  1  input FIFO not full.
- pu_x1..pu_x4  out  32 each  to PU x inputs.
- pu_w1..pu_w4  out  32 each  to PU w inputs.
- pu_out  in  32  PU result.
- res_valid  out  1  result FIFO non-empty.
- res_data  out  32  head of result FIFO (first-word fall-through).
- res_ready  in  1  pop when res_valid && res_ready.
- res_count  out  16  results popped (only with PU_FEEDER_COUNT_EN).

## Operation
- State NOWGT after reset: no issue, vectors may still enter the input FIFO. First accepted w_load → RUN.
- RUN: weight registers are driven onto pu_w1..pu_w4 continuously.
- Issue condition (evaluated every cycle): state RUN, input FIFO non-empty, credit>0, and no w_load accepted this cycle. On issue:
  - The FIFO head is popped into the issue register that drives pu_x1..pu_x4.
  - A 1 is shifted into a PU_LAT-deep valid pipe.
  - credit is decremented.
- No issue: pu_x1..pu_x4 are driven to 0 and a 0 is shifted into the valid pipe.
- Capture: when the valid-pipe tail is 1, pu_out is written into the result FIFO. pu_out is never captured otherwise.
- credit: reset value DEPTH; decremented on issue, incremented on result pop. Simultaneous issue and pop leaves it unchanged. The result FIFO therefore cannot overflow.
- w_ready = 1 when no issued result is still in the valid pipe (in-flight = 0). In NOWGT, w_ready = 1.
- An accepted w_load updates the weights at the edge and suppresses issue in that cycle. Vectors issued afterward use the new weights.
- in_ready = input FIFO not full. A push to a full FIFO is impossible because in_ready gates it.
- Simultaneous push and pop on a full input FIFO is allowed only via pop-first, i.e. in_ready stays registered-full for that cycle.
- FIFO pointers wrap modulo DEPTH. An extra occupancy bit distinguishes full from empty.

## Timing
- Reset (rst=0, async): all outputs are 0 except in_ready=1 and w_ready=1.
  - State, credit, FIFOs, valid pipe and weights are cleared.
  - In-flight PU results are discarded.
  - res_count=0.
- Vector accepted at edge t, with RUN, credit available and FIFO previously empty:
  - Issue register loads at edge t+1.
  - pu_out valid in cycle t+1+PU_LAT.
  - Written at the following edge.
  - res_valid high from cycle t+2+PU_LAT, which is 3 cycles for PU_LAT=1.
- Sustained throughput: 1 vector/cycle while res_ready=1.
- Result order equals input acceptance order.
- res_data is stable while res_valid && !res_ready.

## Configuration
- PU_FEEDER_COUNT_EN defined:
  - res_count port exists.
  - It increments on every result pop.
  - It wraps 0xFFFF→0.
  - It resets to 0.
- Undefined: no res_count port and no counter logic. All other behaviour is identical.

## Test plan
- Ones dot product: w_in all 0x3F800000; vector x=1.0,2.0,3.0,4.0 (0x3F800000,0x40000000,0x40400000,0x40800000) → res_data=0x41200000 (10.0), res_valid 3 cycles after acceptance.
- ReLU: x all 0xBF800000, w all 1.0 → res_data=0x00000000.
- Backpressure (DEPTH=4): res_ready=0, push 10 vectors:
  - 4 are issued, then issue stalls (credit=0).
  - 4 fill the input FIFO and in_ready drops on the 9th.
  - Setting res_ready=1 then drains all results in order.
- Weight reload:
  - w_load asserted with 2 results in flight → w_ready=0 until the pipe empties.
  - The load is accepted on the first cycle w_ready=1.
  - Subsequent results use the new weights (w=2.0, x=1.0 → 0x41000000).
- Reset mid-stream:
  - Assert rst with results queued and in flight.
  - After release: res_valid=0, in_ready=1, state NOWGT.
  - No stale pu_out is captured.
  - No issue occurs until weights are reloaded.

Source files
------------

// File: rtl/pu_feeder_if.sv
// Bundled weight-load, input-vector, PU-side and result signals of pu_feeder.
// slave is the feeder's view; master is the surrounding producer/PU/consumer.
interface pu_feeder_if;
  logic         w_load;
  logic [127:0] w_in;
  logic         w_ready;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic [31:0]  pu_x1, pu_x2, pu_x3, pu_x4;
  logic [31:0]  pu_w1, pu_w2, pu_w3, pu_w4;
  logic [31:0]  pu_out;
  logic         res_valid;
  logic [31:0]  res_data;
  logic         res_ready;

  modport slave (
    input  w_load, w_in, in_valid, in_data, pu_out, res_ready,
    output w_ready, in_ready, pu_x1, pu_x2, pu_x3, pu_x4,
           pu_w1, pu_w2, pu_w3, pu_w4, res_valid, res_data
  );

  modport master (
    output w_load, w_in, in_valid, in_data, pu_out, res_ready,
    input  w_ready, in_ready, pu_x1, pu_x2, pu_x3, pu_x4,
           pu_w1, pu_w2, pu_w3, pu_w4, res_valid, res_data
  );
endinterface

// File: rtl/pu_feeder.sv
// Input-vector FIFO, weight holder, credit-based issue and result FIFO for the 4-input PU.
// Define PU_FEEDER_COUNT_EN to add the 16-bit res_count popped-result counter.
module pu_feeder #(
  parameter int DEPTH  = 4,
  parameter int PU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  pu_feeder_if.slave  bus
`ifdef PU_FEEDER_COUNT_EN
  ,
  output logic [15:0] res_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CRD_ONE  = CW'(1);
  localparam logic [CW-1:0] CRD_FULL = CW'(DEPTH);

  localparam logic [0:0] ST_NOWGT = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [127:0]  w_q, w_d;
  logic [127:0]  x_q, x_d;
  logic [CW-1:0] credit_q, credit_d;
  // Bit 0 marks the issue register; bits 1..PU_LAT track the PU pipeline.
  logic [PU_LAT:0] vpipe_q, vpipe_d;

  logic [127:0] in_mem_q [DEPTH];
  logic [31:0]  res_mem_q [DEPTH];
  logic [AW:0]  in_wr_q, in_rd_q, res_wr_q, res_rd_q;

  logic in_full, in_empty, res_full, res_empty;
  logic w_acc, issue, in_push, res_push, res_pop;

  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[AW] != in_rd_q[AW]) && (in_wr_q[AW-1:0] == in_rd_q[AW-1:0]);
  assign res_empty = (res_wr_q == res_rd_q);
  assign res_full  = (res_wr_q[AW] != res_rd_q[AW]) && (res_wr_q[AW-1:0] == res_rd_q[AW-1:0]);

  assign bus.w_ready   = (state_q == ST_NOWGT) || (vpipe_q == '0);
  assign bus.in_ready  = !in_full;
  assign bus.res_valid = !res_empty;
  assign bus.res_data  = res_empty ? 32'h0 : res_mem_q[res_rd_q[AW-1:0]];

  assign w_acc    = bus.w_load && bus.w_ready;
  assign issue    = (state_q == ST_RUN) && !in_empty && (credit_q != '0) && !w_acc;
  assign in_push  = bus.in_valid && !in_full;
  assign res_push = vpipe_q[PU_LAT] && !res_full;
  assign res_pop  = !res_empty && bus.res_ready;

  assign vpipe_d[0] = issue;
  for (genvar gi = 1; gi <= PU_LAT; gi++) begin : g_vpipe
    assign vpipe_d[gi] = vpipe_q[gi-1];
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    credit_d = credit_q;
    x_d      = issue ? in_mem_q[in_rd_q[AW-1:0]] : 128'h0;
    if (w_acc) begin
      state_d = ST_RUN;
      w_d     = bus.w_in;
    end
    if (issue && !res_pop) begin
      credit_d = credit_q - CRD_ONE;
    end else if (!issue && res_pop) begin
      credit_d = credit_q + CRD_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_NOWGT;
      w_q      <= '0;
      x_q      <= '0;
      credit_q <= CRD_FULL;
      vpipe_q  <= '0;
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      res_wr_q <= '0;
      res_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      x_q      <= x_d;
      credit_q <= credit_d;
      vpipe_q  <= vpipe_d;
      if (in_push)  in_wr_q  <= in_wr_q + PTR_ONE;
      if (issue)    in_rd_q  <= in_rd_q + PTR_ONE;
      if (res_push) res_wr_q <= res_wr_q + PTR_ONE;
      if (res_pop)  res_rd_q <= res_rd_q + PTR_ONE;
    end
  end

  // Storage arrays need no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q[AW-1:0]]   <= bus.in_data;
    if (res_push) res_mem_q[res_wr_q[AW-1:0]] <= bus.pu_out;
  end

  assign bus.pu_x1 = x_q[31:0];
  assign bus.pu_x2 = x_q[63:32];
  assign bus.pu_x3 = x_q[95:64];
  assign bus.pu_x4 = x_q[127:96];
  assign bus.pu_w1 = w_q[31:0];
  assign bus.pu_w2 = w_q[63:32];
  assign bus.pu_w3 = w_q[95:64];
  assign bus.pu_w4 = w_q[127:96];

`ifdef PU_FEEDER_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (res_pop) begin
      count_q <= count_q + 16'd1;
    end
  end
  assign res_count = count_q;
`endif

endmodule

// File: tb/tb_pu_feeder.sv
// Randomized and directed bench for pu_feeder with an integer-valued float32 PU model.
// Expected results are relu(sum x*w) computed from the vectors and weights the bench drove.
module tb_pu_feeder;
  localparam int DEPTH  = 4;
  localparam int PU_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pu_feeder_if bus();
  logic [31:0] pu_out_m = 32'h0;
  assign bus.pu_out = pu_out_m;

`ifdef PU_FEEDER_COUNT_EN
  logic [15:0] res_count;
`endif

  pu_feeder #(.DEPTH(DEPTH), .PU_LAT(PU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PU_FEEDER_COUNT_EN
    ,
    .res_count (res_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int wm [4];
  bit run_m = 1'b0;
  int pop_total = 0;
  logic [127:0] pend_q [$];
  logic [31:0]  exp_q  [$];
  logic [31:0]  got_q  [$];

  function automatic logic [31:0] i2f(int v);
    int a, e;
    if (v == 0) return 32'h0;
    a = (v < 0) ? -v : v;
    e = 0;
    while ((a >> e) > 1) e++;
    return {(v < 0), 8'(127 + e), 23'((a - (1 << e)) << (23 - e))};
  endfunction

  function automatic int f2i(logic [31:0] f);
    int e, m;
    e = int'(f[30:23]);
    if (e < 127 || e > 150) return 0;
    m = int'({1'b1, f[22:0]}) >>> (150 - e);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [127:0] mk_vec(int a, int b, int c, int d);
    return {i2f(d), i2f(c), i2f(b), i2f(a)};
  endfunction

  function automatic logic [31:0] expect_of(logic [127:0] x);
    int s = 0;
    for (int i = 0; i < 4; i++) s += f2i(x[32*i +: 32]) * wm[i];
    return (s > 0) ? i2f(s) : 32'h0;
  endfunction

  // Pipelined PU peer: one-cycle latency, ReLU of the dot product.
  always @(posedge clk) begin
    int s;
    s = f2i(bus.pu_x1) * f2i(bus.pu_w1) + f2i(bus.pu_x2) * f2i(bus.pu_w2)
      + f2i(bus.pu_x3) * f2i(bus.pu_w3) + f2i(bus.pu_x4) * f2i(bus.pu_w4);
    pu_out_m <= (s > 0) ? i2f(s) : 32'h0;
  end

  task automatic step();
    if (bus.w_load && bus.w_ready) begin
      for (int i = 0; i < 4; i++) wm[i] = f2i(bus.w_in[32*i +: 32]);
      if (!run_m) begin
        while (pend_q.size() > 0) exp_q.push_back(expect_of(pend_q.pop_front()));
        run_m = 1'b1;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      if (run_m) exp_q.push_back(expect_of(bus.in_data));
      else       pend_q.push_back(bus.in_data);
    end
    if (bus.res_valid && bus.res_ready) begin
      got_q.push_back(bus.res_data);
      pop_total++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(int n, string tag);
    int c = 0;
    while (got_q.size() < n && c < 60) begin step(); c++; end
    total++;
    if (got_q.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: got %0d results required %0d", tag, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.w_load = 0; bus.w_in = '0; bus.in_valid = 0; bus.in_data = '0; bus.res_ready = 0;
    rst = 1'b0;
    #3;
    total++;
    if ({bus.in_ready, bus.w_ready, bus.res_valid} !== 3'b110 || bus.res_data !== 32'h0
        || bus.pu_x1 !== 32'h0 || bus.pu_w4 !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: in_ready=%b w_ready=%b res_valid=%b res_data=%h pu_x1=%h pu_w4=%h required 1 1 0 0 0 0",
               bus.in_ready, bus.w_ready, bus.res_valid, bus.res_data, bus.pu_x1, bus.pu_w4);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ones_dot();
    got_q.delete(); exp_q.delete();
    bus.w_load = 1; bus.w_in = {4{32'h3F800000}};
    step();
    bus.w_load = 0;
    bus.in_valid = 1; bus.in_data = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    step();
    bus.in_valid = 0;
    step();
    total++;
    if (bus.pu_x1 !== 32'h3F800000 || bus.pu_x4 !== 32'h40800000 || bus.pu_w2 !== 32'h3F800000) begin
      bad++;
      $display("FAIL ones_issue: pu_x1=%h pu_x4=%h pu_w2=%h required 3f800000 40800000 3f800000",
               bus.pu_x1, bus.pu_x4, bus.pu_w2);
    end
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL ones_early1: res_valid=%b required 0", bus.res_valid);
    end
    step();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL ones_early2: res_valid=%b required 0", bus.res_valid);
    end
    step();
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h41200000) begin
      bad++;
      $display("FAIL ones_result: res_valid=%b res_data=%h required 1 41200000", bus.res_valid, bus.res_data);
    end
    bus.res_ready = 1;
    step();
    bus.res_ready = 0;
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL ones_pop: res_valid=%b required 0", bus.res_valid);
    end
  endtask

  task automatic test_relu();
    got_q.delete(); exp_q.delete();
    bus.res_ready = 1;
    bus.in_valid = 1; bus.in_data = {4{32'hBF800000}};
    step();
    bus.in_valid = 0;
    wait_results(1, "relu");
    total++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0) begin
      bad++;
      $display("FAIL relu_result: count=%0d data=%h required 1 00000000",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hX);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int c = 0;
    got_q.delete(); exp_q.delete();
    bus.res_ready = 0;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1; bus.in_data = mk_vec(k + 1, 1, 0, 0);
      if (bus.in_ready) k++;
      step();
    end
    total++;
    if (k != 8 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.pu_x1 !== 32'h0) begin
      bad++;
      $display("FAIL bp_stall: accepted=%0d in_ready=%b res_valid=%b pu_x1=%h required 8 0 1 0",
               k, bus.in_ready, bus.res_valid, bus.pu_x1);
    end
    bus.res_ready = 1;
    while (k < 10 && c < 40) begin
      bus.in_valid = 1; bus.in_data = mk_vec(k + 1, 1, 0, 0);
      if (bus.in_ready) k++;
      step();
      c++;
    end
    bus.in_valid = 0;
    wait_results(10, "bp");
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      total++;
      if (got_q[i] !== i2f(i + 2)) begin
        bad++; $display("FAIL bp_order[%0d]: got %h required %h", i, got_q[i], i2f(i + 2));
      end
    end
  endtask

  task automatic test_weight_reload();
    int n = 0;
    got_q.delete(); exp_q.delete();
    bus.res_ready = 1;
    bus.in_valid = 1; bus.in_data = mk_vec(1, 1, 1, 1);
    step(); step();
    bus.in_valid = 0;
    bus.w_load = 1; bus.w_in = {4{32'h40000000}};
    total++;
    if (bus.w_ready !== 1'b0) begin
      bad++; $display("FAIL reload_busy: w_ready=%b required 0", bus.w_ready);
    end
    while (bus.w_ready !== 1'b1 && n < 20) begin
      total++;
      if (bus.pu_w1 !== 32'h3F800000) begin
        bad++; $display("FAIL reload_hold: pu_w1=%h required 3f800000", bus.pu_w1);
      end
      step();
      n++;
    end
    step();
    bus.w_load = 0;
    total++;
    if (bus.pu_w1 !== 32'h40000000 || bus.pu_w4 !== 32'h40000000) begin
      bad++; $display("FAIL reload_weights: pu_w1=%h pu_w4=%h required 40000000", bus.pu_w1, bus.pu_w4);
    end
    bus.in_valid = 1; bus.in_data = mk_vec(1, 1, 1, 1);
    step();
    bus.in_valid = 0;
    wait_results(3, "reload");
    total++;
    if (got_q.size() != 3 || got_q[0] !== 32'h40800000 || got_q[1] !== 32'h40800000
        || got_q[2] !== 32'h41000000) begin
      bad++;
      $display("FAIL reload_results: count=%0d last=%h required 3 results 40800000 40800000 41000000",
               got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'hX);
    end
  endtask

  task automatic test_reset_midstream();
    bus.res_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.in_data = mk_vec(i + 1, 0, 0, 0);
      step();
    end
    bus.in_valid = 0;
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.w_ready !== 1'b1
        || bus.pu_x1 !== 32'h0 || bus.pu_w1 !== 32'h0) begin
      bad++;
      $display("FAIL midreset_outputs: res_valid=%b in_ready=%b w_ready=%b pu_x1=%h pu_w1=%h required 0 1 1 0 0",
               bus.res_valid, bus.in_ready, bus.w_ready, bus.pu_x1, bus.pu_w1);
    end
    got_q.delete(); exp_q.delete(); pend_q.delete();
    run_m = 1'b0; pop_total = 0;
    for (int i = 0; i < 4; i++) wm[i] = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_data = mk_vec(1, 2, 3, 4);
    step();
    bus.in_data = mk_vec(-1, -1, -1, -1);
    step();
    bus.in_valid = 0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bus.pu_x1 !== 32'h0 || bus.res_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_idle[%0d]: pu_x1=%h res_valid=%b required 0 0", i, bus.pu_x1, bus.res_valid);
      end
      step();
    end
    bus.w_load = 1; bus.w_in = {4{32'h3F800000}};
    step();
    bus.w_load = 0;
    bus.res_ready = 1;
    wait_results(2, "midreset");
    total++;
    if (got_q.size() != 2 || got_q[0] !== 32'h41200000 || got_q[1] !== 32'h0) begin
      bad++;
      $display("FAIL midreset_results: count=%0d first=%h required 2 results 41200000 00000000",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hX);
    end
    step(); step();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_extra: res_valid=%b required 0", bus.res_valid);
    end
  endtask

  task automatic test_random();
    int n = 0;
    bit held;
    logic [31:0] hold_d;
    got_q.delete(); exp_q.delete();
    bus.res_ready = 1;
    bus.w_load = 1;
    for (int i = 0; i < 4; i++) bus.w_in[32*i +: 32] = i2f(int'($urandom_range(0, 6)) - 3);
    while (bus.w_ready !== 1'b1 && n < 20) begin step(); n++; end
    step();
    bus.w_load = 0;
    for (int c = 0; c < 300; c++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_data   = mk_vec(int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4,
                             int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4);
      bus.res_ready = ($urandom_range(0, 9) < 6);
      held   = bus.res_valid && !bus.res_ready;
      hold_d = bus.res_data;
      step();
      if (held) begin
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== hold_d) begin
          bad++;
          $display("FAIL rand_stable[%0d]: res_valid=%b res_data=%h required 1 %h", c, bus.res_valid, bus.res_data, hold_d);
        end
      end
    end
    bus.in_valid = 0; bus.res_ready = 1;
    n = 0;
    while ((got_q.size() < exp_q.size() || bus.res_valid) && n < 60) begin step(); n++; end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count: got %0d results required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
`ifdef PU_FEEDER_COUNT_EN
    total++;
    if (res_count !== 16'(pop_total)) begin
      bad++; $display("FAIL rand_res_count: got %0d required %0d", res_count, pop_total & 16'hFFFF);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) wm[i] = 0;
    test_reset();
    test_ones_dot();
    test_relu();
    test_backpressure();
    test_weight_reload();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
